// File: rtl/arp_requester.sv
// ARP requester: broadcasts a request for a target IPv4 address and waits for the matching reply.
// States: IDLE accept request | SEND emit 42-byte frame | WAIT reply or timeout | DONE result strobe
module arp_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] hw_addr_i,
  input  logic [31:0] ipv4_addr_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_ip_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic        rsp_ok_o,
  output logic [47:0] rsp_mac_o,
  input  logic        mac_rx_valid_i,
  input  logic [7:0]  mac_rx_data_i,
  output logic        mac_tx_valid_o,
  output logic [7:0]  mac_tx_data_o,
  input  logic        mac_tx_ack_i
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX     = RW'(MAX_RETRIES);
  localparam logic [5:0]    LAST_BYTE = 6'd41;
  localparam logic [5:0]    RX_FULL   = 6'd42;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [5:0]    tx_idx;
  logic [TW-1:0] tcount;
  logic [RW-1:0] retries;
  logic [31:0]   target_ip;

  logic [5:0]    rx_idx;
  logic          rx_bad;
  logic [47:0]   rx_sha;
  logic          rx_byte_ok;
  logic          rx_done;

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] k);
    case (k)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      3'd5:    return mac[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] k);
    case (k)
      2'd0:    return ip[31:24];
      2'd1:    return ip[23:16];
      2'd2:    return ip[15:8];
      default: return ip[7:0];
    endcase
  endfunction

  function automatic logic [7:0] tx_byte(input logic [5:0] i, input logic [47:0] mac,
                                         input logic [31:0] own_ip, input logic [31:0] tgt);
    logic [7:0] b;
    b = 8'h00;
    if (i <= 6'd5) begin
      b = 8'hFF;
    end else if (i <= 6'd11) begin
      b = mac_byte(mac, 3'(i - 6'd6));
    end else begin
      case (i)
        6'd12:   b = 8'h08;
        6'd13:   b = 8'h06;
        6'd14:   b = 8'h00;
        6'd15:   b = 8'h01;
        6'd16:   b = 8'h08;
        6'd17:   b = 8'h00;
        6'd18:   b = 8'h06;
        6'd19:   b = 8'h04;
        6'd20:   b = 8'h00;
        6'd21:   b = 8'h01;
        default: begin
          if (i >= 6'd22 && i <= 6'd27)
            b = mac_byte(mac, 3'(i - 6'd22));
          else if (i >= 6'd28 && i <= 6'd31)
            b = ip_byte(own_ip, 2'(i - 6'd28));
          else if (i >= 6'd38 && i <= 6'd41)
            b = ip_byte(tgt, 2'(i - 6'd38));
        end
      endcase
    end
    return b;
  endfunction

  // Reply header matches the request header except oper (byte 21) is 2.
  always_comb begin
    rx_byte_ok = 1'b1;
    if (rx_idx <= 6'd5)
      rx_byte_ok = (mac_rx_data_i == mac_byte(hw_addr_i, 3'(rx_idx)));
    else if (rx_idx >= 6'd12 && rx_idx <= 6'd20)
      rx_byte_ok = (mac_rx_data_i == tx_byte(rx_idx, hw_addr_i, ipv4_addr_i, target_ip));
    else if (rx_idx == 6'd21)
      rx_byte_ok = (mac_rx_data_i == 8'h02);
    else if (rx_idx >= 6'd28 && rx_idx <= 6'd31)
      rx_byte_ok = (mac_rx_data_i == ip_byte(target_ip, 2'(rx_idx - 6'd28)));
    else if (rx_idx >= 6'd38 && rx_idx <= 6'd41)
      rx_byte_ok = (mac_rx_data_i == ip_byte(ipv4_addr_i, 2'(rx_idx - 6'd38)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_idx <= '0;
      rx_bad <= 1'b0;
      rx_sha <= '0;
    end else if (mac_rx_valid_i) begin
      if (rx_idx != RX_FULL)
        rx_idx <= rx_idx + 6'd1;
      if (rx_idx == 6'd0)
        rx_bad <= ~rx_byte_ok;
      else if (!rx_byte_ok)
        rx_bad <= 1'b1;
      if (rx_idx >= 6'd22 && rx_idx <= 6'd27)
        rx_sha <= {rx_sha[39:0], mac_rx_data_i};
    end else begin
      rx_idx <= '0;
    end
  end

  // rx_idx only holds 42 during the falling cycle, so this is a single-cycle pulse.
  assign rx_done = !mac_rx_valid_i && (rx_idx == RX_FULL) && !rx_bad;

  assign req_ready_o = (state == S_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      tx_idx         <= '0;
      tcount         <= '0;
      retries        <= '0;
      target_ip      <= '0;
      mac_tx_valid_o <= 1'b0;
      mac_tx_data_o  <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_ok_o       <= 1'b0;
      rsp_mac_o      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            target_ip      <= req_ip_i;
            retries        <= '0;
            tx_idx         <= '0;
            mac_tx_valid_o <= 1'b1;
            mac_tx_data_o  <= 8'hFF;
            state          <= S_SEND;
          end
        end
        S_SEND: begin
          if (mac_tx_valid_o && mac_tx_ack_i) begin
            if (tx_idx == LAST_BYTE) begin
              mac_tx_valid_o <= 1'b0;
              tcount         <= '0;
              state          <= S_WAIT;
            end else begin
              tx_idx        <= tx_idx + 6'd1;
              mac_tx_data_o <= tx_byte(tx_idx + 6'd1, hw_addr_i, ipv4_addr_i, target_ip);
            end
          end
        end
        S_WAIT: begin
          if (rx_done) begin
            rsp_valid_o <= 1'b1;
            rsp_ok_o    <= 1'b1;
            rsp_mac_o   <= rx_sha;
            state       <= S_DONE;
          end else if (tcount == T_LAST) begin
            if (retries < R_MAX) begin
              retries        <= retries + 1'b1;
              tx_idx         <= '0;
              mac_tx_valid_o <= 1'b1;
              mac_tx_data_o  <= 8'hFF;
              state          <= S_SEND;
            end else begin
              rsp_valid_o <= 1'b1;
              rsp_ok_o    <= 1'b0;
              rsp_mac_o   <= '0;
              state       <= S_DONE;
            end
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        S_DONE: begin
          rsp_valid_o <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
